sprite_motion_ctrl: RTL and testbench

- Frame-synchronous position controller for the on-screen square sprite driven by the VGA timing generator.
- Latches signed tilt/movement samples from the sensor path.
- Applies exactly one bounded position update per enabled frame, during vertical blanking.
- Produces a registered per-pixel "sprite on" flag for the colour mux, plus frame and edge-hit status pulses.

---
 rtl/sprite_motion_ctrl.sv | 153 +++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Frame-synchronous position controller for a SIZE x SIZE sprite. It latches
//   signed dx/dy tilt samples and applies one bounded position update per
//   enabled frame tick. The tick fires at line TICK_LINE, which is in vertical
//   blanking, so a new position never appears part-way through a visible frame.
//   It also produces a registered per-pixel "inside sprite" flag.
//
// Ports
//   pixel_clk        pixel clock (only clock)
//   rst_n            asynchronous active-low reset
//   hcounter[10:0]   current pixel column from the VGA timing generator
//   vcounter[10:0]   current pixel line from the VGA timing generator
//   movementData[9:0] {dx[4:0], dy[4:0]}, two's complement, valid on move_valid
//   move_valid       one-cycle strobe qualifying movementData
//   hold             1 = ignore frame ticks (sprite frozen, divider frozen)
//   h_min/h_max      sprite left/right column (h_max = h_min+SIZE-1)
//   v_min/v_max      sprite top/bottom line  (v_max = v_min+SIZE-1)
//   sprite_on        registered: previous (hcounter,vcounter) lies in the sprite
//   frame_done       one-cycle pulse when a position update commits
//   edge_hit         one-cycle pulse with frame_done when either axis clamped
module sprite_motion_ctrl #(
  parameter int HLINES    = 640,
  parameter int VLINES    = 480,
  parameter int SIZE      = 40,
  parameter int TICK_LINE = 481,
  parameter int FRAME_DIV = 1,
  parameter int H_INIT    = 300,
  parameter int V_INIT    = 220
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [10:0] hcounter,
  input  logic [10:0] vcounter,
  input  logic [9:0]  movementData,
  input  logic        move_valid,
  input  logic        hold,
  output logic [10:0] h_min,
  output logic [10:0] h_max,
  output logic [10:0] v_min,
  output logic [10:0] v_max,
  output logic        sprite_on,
  output logic        frame_done,
  output logic        edge_hit
);

  localparam logic signed [12:0] H_LIM = 13'(HLINES - SIZE);
  localparam logic signed [12:0] V_LIM = 13'(VLINES - SIZE);
  localparam logic [10:0]        SPAN  = 11'(SIZE - 1);
  localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, CALC, CLAMP, COMMIT} state_t;

  state_t            state, state_nxt;
  logic              tick, tick_q, tick_rise;
  logic        [7:0] div_cnt, div_cnt_nxt;
  logic signed [4:0] dx, dy;
  logic signed [12:0] dx_ext, dy_ext;
  logic signed [12:0] cand_h_p0, cand_v_p0;
  logic        [11:0] h_clamp, v_clamp;   // {clamped flag, value}

  // Returns {flag, value}: value limited to [0, lim], flag set only when the
  // candidate lay strictly outside that range.
  function automatic logic [11:0] clamp_axis(input logic signed [12:0] cand,
                                             input logic signed [12:0] lim);
    if (cand < 13'sd0)
      return {1'b1, 11'd0};
    else if (cand > lim)
      return {1'b1, lim[10:0]};
    else
      return {1'b0, cand[10:0]};
  endfunction

  assign tick      = (vcounter == 11'(TICK_LINE)) && (hcounter == 11'd0);
  assign tick_rise = tick && !tick_q;
  assign dx_ext    = {{8{dx[4]}}, dx};
  assign dy_ext    = {{8{dy[4]}}, dy};
  assign h_clamp   = clamp_axis(cand_h_p0, H_LIM);
  assign v_clamp   = clamp_axis(cand_v_p0, V_LIM);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    case (state)
      IDLE: begin
        if (tick_rise && !hold) begin
          if (FRAME_DIV == 1 || div_cnt == DIV_LAST) begin
            div_cnt_nxt = 8'd0;
            state_nxt   = CALC;
          end else begin
            div_cnt_nxt = div_cnt + 8'd1;
          end
        end
      end
      CALC:    state_nxt = CLAMP;
      CLAMP:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= 1'b0;
      div_cnt    <= 8'd0;
      dx         <= '0;
      dy         <= '0;
      h_min      <= 11'(H_INIT);
      h_max      <= 11'(H_INIT + SIZE - 1);
      v_min      <= 11'(V_INIT);
      v_max      <= 11'(V_INIT + SIZE - 1);
      sprite_on  <= 1'b0;
      frame_done <= 1'b0;
      edge_hit   <= 1'b0;
    end else begin
      tick_q  <= tick;
      div_cnt <= div_cnt_nxt;
      // A sample landing during CALC is taken at the same edge that captures
      // the candidates, so the in-flight update still uses the old dx/dy.
      if (move_valid) begin
        dx <= movementData[9:5];
        dy <= movementData[4:0];
      end
      sprite_on  <= (hcounter >= h_min) && (hcounter <= h_max) &&
                    (vcounter >= v_min) && (vcounter <= v_max);
      // Clamped values are written on the edge entering COMMIT, so the new
      // position and the pulses are visible during the COMMIT cycle.
      frame_done <= (state == CLAMP);
      edge_hit   <= (state == CLAMP) && (h_clamp[11] || v_clamp[11]);
      if (state == CLAMP) begin
        h_min <= h_clamp[10:0];
        h_max <= h_clamp[10:0] + SPAN;
        v_min <= v_clamp[10:0];
        v_max <= v_clamp[10:0] + SPAN;
      end
    end
  end

  // Stage p0: candidate positions. Tilt in dy moves the sprite horizontally
  // and dx moves it vertically, both with inverted sense.
  always_ff @(posedge pixel_clk) begin
    if (state == CALC) begin
      cand_h_p0 <= $signed({2'b00, h_min}) - dy_ext;
      cand_v_p0 <= $signed({2'b00, v_min}) - dx_ext;
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: two instances (FRAME_DIV=1 and FRAME_DIV=4)
// share stimulus; a behavioural model tracks positions, divider and latched tilt.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hc, vc;
  logic [9:0]  md;
  logic        mv, hold;
  logic [10:0] h_min, h_max, v_min, v_max;
  logic        sprite_on, frame_done, edge_hit;
  logic [10:0] h_min4, h_max4, v_min4, v_max4;
  logic        sprite_on4, frame_done4, edge_hit4;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int ph, pv, p4h, p4v, mdx, mdy, cnt4;

  always #20 clk = ~clk;

  sprite_motion_ctrl dut (
    .pixel_clk(clk), .rst_n(rst_n), .hcounter(hc), .vcounter(vc),
    .movementData(md), .move_valid(mv), .hold(hold),
    .h_min(h_min), .h_max(h_max), .v_min(v_min), .v_max(v_max),
    .sprite_on(sprite_on), .frame_done(frame_done), .edge_hit(edge_hit));

  sprite_motion_ctrl #(.FRAME_DIV(4)) dut4 (
    .pixel_clk(clk), .rst_n(rst_n), .hcounter(hc), .vcounter(vc),
    .movementData(md), .move_valid(mv), .hold(hold),
    .h_min(h_min4), .h_max(h_max4), .v_min(v_min4), .v_max(v_max4),
    .sprite_on(sprite_on4), .frame_done(frame_done4), .edge_hit(edge_hit4));

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sx5(input logic [4:0] v);
    return v[4] ? int'(v) - 32 : int'(v);
  endfunction

  function automatic int clampv(input int c, input int lim, output bit f);
    f = (c < 0) || (c > lim);
    if (c < 0)   return 0;
    if (c > lim) return lim;
    return c;
  endfunction

  function automatic bit inside_sp(input int h, input int v, input int x0, input int y0);
    return (h >= x0) && (h <= x0 + 39) && (v >= y0) && (v <= y0 + 39);
  endfunction

  task automatic model_reset();
    ph = 300; pv = 220; p4h = 300; p4v = 220;
    mdx = 0; mdy = 0; cnt4 = 0;
  endtask

  task automatic check_pos(input string tag);
    chk({tag, ".h_min"}, h_min, ph);
    chk({tag, ".h_max"}, h_max, ph + 39);
    chk({tag, ".v_min"}, v_min, pv);
    chk({tag, ".v_max"}, v_max, pv + 39);
    chk({tag, ".h_min4"}, h_min4, p4h);
    chk({tag, ".v_min4"}, v_min4, p4v);
    chk({tag, ".h_max4"}, h_max4, p4h + 39);
    chk({tag, ".v_max4"}, v_max4, p4v + 39);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; mv = 1'b0;
    #15;
    model_reset();
    check_pos("rst");
    chk("rst.frame_done", frame_done, 0);
    chk("rst.edge_hit", edge_hit, 0);
    chk("rst.sprite_on", sprite_on, 0);
    #10 rst_n = 1'b1;
  endtask

  task automatic load(input logic [9:0] d);
    @(posedge clk); #1;
    md = d; mv = 1'b1;
    @(posedge clk); #1;
    mv = 1'b0;
    mdx = sx5(d[9:5]);
    mdy = sx5(d[4:0]);
  endtask

  // One frame tick; optionally strobe a new sample during the CALC cycle.
  task automatic frame(input bit calc_mv, input logic [9:0] calc_d);
    bit c1, c4, fh, fv, e1, e4;
    int nh, nv;
    c1 = !hold;
    c4 = 1'b0;
    if (!hold) begin
      cnt4++;
      if (cnt4 == 4) begin c4 = 1'b1; cnt4 = 0; end
    end
    nh = clampv(ph - mdy, 600, fh);
    nv = clampv(pv - mdx, 440, fv);
    e1 = c1 && (fh || fv);
    if (c1) begin ph = nh; pv = nv; end
    nh = clampv(p4h - mdy, 600, fh);
    nv = clampv(p4v - mdx, 440, fv);
    e4 = c4 && (fh || fv);
    if (c4) begin p4h = nh; p4v = nv; end

    @(posedge clk); #1;              // tick cycle T
    vc = 11'd481; hc = 11'd0;
    @(posedge clk); #1;              // T+1
    vc = 11'd0; hc = 11'd5;
    if (calc_mv) begin md = calc_d; mv = 1'b1; end
    @(posedge clk); #1;              // T+2
    mv = 1'b0;
    if (calc_mv) begin mdx = sx5(calc_d[9:5]); mdy = sx5(calc_d[4:0]); end
    chk("fd_early", frame_done, 0);
    chk("fd4_early", frame_done4, 0);
    @(posedge clk); #1;              // T+3
    chk("frame_done", frame_done, int'(c1));
    chk("edge_hit", edge_hit, int'(e1));
    chk("frame_done4", frame_done4, int'(c4));
    chk("edge_hit4", edge_hit4, int'(e4));
    check_pos("commit");
    @(posedge clk); #1;              // T+4
    chk("fd_late", frame_done, 0);
    chk("eh_late", edge_hit, 0);
    chk("fd4_late", frame_done4, 0);
  endtask

  task automatic scan_point(input int h, input int v);
    @(posedge clk); #1;
    hc = 11'(h); vc = 11'(v);
    @(posedge clk); #1;
    chk("sprite_on", sprite_on, int'(inside_sp(h, v, ph, pv)));
    chk("sprite_on4", sprite_on4, int'(inside_sp(h, v, p4h, p4v)));
  endtask

  initial begin
    int rows[7];
    rows = '{219, 220, 221, 240, 258, 259, 260};
    rst_n = 1'b0; hc = 11'd5; vc = 11'd0; md = '0; mv = 1'b0; hold = 1'b0;
    model_reset();
    do_reset();

    // idle frames: no movement, pulses each frame, no edge hit
    repeat (3) frame(1'b0, 10'd0);

    // raster window at reset position, counters held per pixel
    foreach (rows[r])
      for (int h = 295; h <= 344; h++) begin
        @(posedge clk); #1;
        hc = 11'(h); vc = 11'(rows[r]);
        @(posedge clk); #1;
        chk("scan", sprite_on, int'(inside_sp(h, rows[r], ph, pv)));
      end
    hc = 11'd5; vc = 11'd0;

    // dx=+3, dy=-2
    load(10'b00011_11110);
    frame(1'b0, 10'd0);

    // sample arriving in CALC applies only from the next frame
    load(10'b00011_00000);
    frame(1'b1, 10'b00111_00000);
    frame(1'b0, 10'd0);

    // clamp low on v, then exactly 0 is not flagged
    do_reset();
    load(10'b01111_00000);
    repeat (14) frame(1'b0, 10'd0);
    load(10'b01000_00000);
    frame(1'b0, 10'd0);
    chk("v_at_2", v_min, 2);
    load(10'b00101_00000);
    frame(1'b0, 10'd0);
    frame(1'b0, 10'd0);
    load(10'b00000_00000);
    frame(1'b0, 10'd0);

    // clamp high on h, then exactly at the limit is not flagged
    load(10'b00000_10001);
    repeat (19) frame(1'b0, 10'd0);
    load(10'b00000_10011);
    frame(1'b0, 10'd0);
    chk("h_at_598", h_min, 598);
    load(10'b00000_10000);
    frame(1'b0, 10'd0);
    load(10'b00000_00000);
    frame(1'b0, 10'd0);

    // divider: 8 ticks, hold for 4, then 4 more
    do_reset();
    load(10'b00001_00000);
    repeat (8) frame(1'b0, 10'd0);
    chk("div4_v", v_min4, 218);
    hold = 1'b1;
    repeat (4) frame(1'b0, 10'd0);
    hold = 1'b0;
    repeat (4) frame(1'b0, 10'd0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) load(10'($urandom));
      hold = ($urandom_range(0, 7) == 0);
      frame($urandom_range(0, 3) == 0, 10'($urandom));
    end
    hold = 1'b0;
    for (int i = 0; i < 150; i++)
      scan_point(int'($urandom_range(0, 799)), int'($urandom_range(0, 479)));
    for (int i = 0; i < 40; i++)
      scan_point(ph + int'($urandom_range(0, 41)) - 1, pv + int'($urandom_range(0, 41)) - 1);
    hc = 11'd5; vc = 11'd0;

    // reset during CALC aborts the update
    load(10'b00011_00000);
    frame(1'b0, 10'd0);
    @(posedge clk); #1;
    vc = 11'd481; hc = 11'd0;
    @(posedge clk); #1;
    vc = 11'd0; hc = 11'd5;
    rst_n = 1'b0;
    #5;
    model_reset();
    check_pos("abort");
    #5 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort.frame_done", frame_done, 0);
      chk("abort.h_min", h_min, 300);
      chk("abort.v_min", v_min, 220);
    end
    frame(1'b0, 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
